// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   state_e   : sequencer FSM encoding (HOLD = 0, RELEASE = 1, RUN = 2)
//   CAUSE_*   : bit positions inside the sticky reset-cause vector
//   max_u     : helper for sizing the shared hold/stage counter
package rst_seq_pkg;

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StRelease = 2'd1,
        StRun     = 2'd2
    } state_e;

    localparam int unsigned CAUSE_EXT = 0;
    localparam int unsigned CAUSE_SW  = 1;
    localparam int unsigned CAUSE_WDT = 2;
    localparam int unsigned CAUSE_W   = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset deassertion synchroniser.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset (asserts immediately)
//   o_rst_s : active-low reset, released on the SYNC_STAGES-th edge after i_rst_n rises
module rst_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign o_rst_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Parametrised reset sequencer.
//   i_clk       : system clock
//   i_rst_n     : asynchronous active-low board reset
//   i_sw_rst    : software reset request (sampled each edge)
//   i_wdt_rst   : watchdog reset request (sampled each edge)
//   i_cause_clr : clears the sticky cause bits
//   o_rst       : active-high per-channel resets, released channel 0 first
//   o_ready     : all channels released
//   o_cause     : sticky cause {wdt, sw, ext}
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int unsigned N_CH        = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_DELAY = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_sw_rst,
    input  logic                i_wdt_rst,
    input  logic                i_cause_clr,
    output logic [N_CH-1:0]     o_rst,
    output logic                o_ready,
    output logic [CAUSE_W-1:0]  o_cause
);

    localparam int unsigned CntW = $clog2(max_u(HOLD_CYCLES, STAGE_DELAY) + 1);
    localparam int unsigned IdxW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CAUSE_W-1:0] CauseRst = CAUSE_W'(1 << CAUSE_EXT);

    logic               rst_s;
    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [N_CH-1:0]    rst_q, rst_d;
    logic               ready_q, ready_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;

    logic req, hold_done, stage_done, last_ch;

    rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .o_rst_s(rst_s)
    );

    assign req        = i_sw_rst | i_wdt_rst;
    assign hold_done  = (cnt_q == CntW'(HOLD_CYCLES - 1));
    assign stage_done = (cnt_q == CntW'(STAGE_DELAY - 1));
    // idx_q names the next channel to be released while in RELEASE
    assign last_ch    = (idx_q == IdxW'(N_CH - 1));

    // State register
    always_ff @(posedge i_clk or negedge rst_s) begin
        if (!rst_s) begin
            state_q <= StHold;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (req) begin
            state_d = StHold;
        end else begin
            unique case (state_q)
                StHold:    if (hold_done) state_d = (N_CH == 1) ? StRun : StRelease;
                StRelease: if (stage_done && last_ch) state_d = StRun;
                StRun:     state_d = StRun;
                default:   state_d = StHold;
            endcase
        end
    end

    // Next values of the registered outputs, counter and channel index
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        if (req) begin
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
        end else begin
            unique case (state_q)
                StHold: begin
                    rst_d   = '1;
                    ready_d = 1'b0;
                    if (hold_done) begin
                        cnt_d    = '0;
                        rst_d[0] = 1'b0;
                        idx_d    = IdxW'(1);
                        if (N_CH == 1) ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StRelease: begin
                    if (stage_done) begin
                        cnt_d = '0;
                        for (int k = 0; k < N_CH; k++) begin
                            if (IdxW'(k) == idx_q) rst_d[k] = 1'b0;
                        end
                        idx_d = idx_q + 1'b1;
                        if (last_ch) ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    rst_d   = '0;
                    ready_d = 1'b1;
                end
                default: begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '1;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    // Cause: clear first, then requests OR in so a same-cycle set wins
    always_comb begin
        cause_d            = i_cause_clr ? '0 : cause_q;
        cause_d[CAUSE_SW]  = cause_d[CAUSE_SW] | i_sw_rst;
        cause_d[CAUSE_WDT] = cause_d[CAUSE_WDT] | i_wdt_rst;
    end

    always_ff @(posedge i_clk or negedge rst_s) begin
        if (!rst_s) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            cause_q <= CauseRst;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    assign o_rst   = rst_q;
    assign o_ready = ready_q;
    assign o_cause = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: a 3-channel instance and a 1-channel instance
// share the same stimulus (SYNC_STAGES=2, HOLD_CYCLES=4, STAGE_DELAY=3).
module tb_rst_seq;

    logic       clk;
    logic       rst_n;
    logic       sw;
    logic       wdt;
    logic       clr;
    logic [2:0] rst3;
    logic       rdy3;
    logic [2:0] cause3;
    logic [0:0] rst1;
    logic       rdy1;
    logic [2:0] cause1;

    int n_checks = 0;
    int n_fail   = 0;

    rst_seq #(
        .N_CH       (3),
        .SYNC_STAGES(2),
        .HOLD_CYCLES(4),
        .STAGE_DELAY(3)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sw_rst   (sw),
        .i_wdt_rst  (wdt),
        .i_cause_clr(clr),
        .o_rst      (rst3),
        .o_ready    (rdy3),
        .o_cause    (cause3)
    );

    rst_seq #(
        .N_CH       (1),
        .SYNC_STAGES(2),
        .HOLD_CYCLES(4),
        .STAGE_DELAY(3)
    ) dut1 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sw_rst   (sw),
        .i_wdt_rst  (wdt),
        .i_cause_clr(clr),
        .o_rst      (rst1),
        .o_ready    (rdy1),
        .o_cause    (cause1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 1'b0;
        wdt   = 1'b0;
        clr   = 1'b0;

        // Power-on
        ticks(5);
        check("por_rst",   32'(rst3),   32'h7);
        check("por_rdy",   32'(rdy3),   32'h0);
        check("por_cause", 32'(cause3), 32'h1);
        check("por_rst1",  32'(rst1),   32'h1);
        rst_n = 1'b1;
        ticks(2);                                   // E0
        check("e0_rst",    32'(rst3),   32'h7);
        ticks(3);
        check("e0p3_rst",  32'(rst3),   32'h7);
        check("e0p3_rst1", 32'(rst1),   32'h1);
        tick();                                     // E0+4
        check("e0p4_rst",  32'(rst3),   32'h6);
        check("e0p4_rdy",  32'(rdy3),   32'h0);
        check("e0p4_rst1", 32'(rst1),   32'h0);
        check("e0p4_rdy1", 32'(rdy1),   32'h1);
        ticks(2);
        check("e0p6_rst",  32'(rst3),   32'h6);
        tick();                                     // E0+7
        check("e0p7_rst",  32'(rst3),   32'h4);
        check("e0p7_cause", 32'(cause3), 32'h1);

        // Watchdog during RELEASE, sampled at E0+8
        wdt = 1'b1;
        tick();
        wdt = 1'b0;
        check("wdt_rst",   32'(rst3),   32'h7);
        check("wdt_rdy",   32'(rdy3),   32'h0);
        check("wdt_cause", 32'(cause3), 32'h5);
        check("wdt_rst1",  32'(rst1),   32'h1);
        check("wdt_rdy1",  32'(rdy1),   32'h0);
        ticks(3);
        check("wdt_p3_rst", 32'(rst3),  32'h7);
        tick();                                     // E0+12
        check("wdt_p4_rst", 32'(rst3),  32'h6);
        ticks(3);
        check("wdt_p7_rst", 32'(rst3),  32'h4);
        ticks(2);
        check("wdt_p9_rdy", 32'(rdy3),  32'h0);
        tick();
        check("wdt_p10_rst", 32'(rst3), 32'h0);
        check("wdt_p10_rdy", 32'(rdy3), 32'h1);

        // Software reset in RUN; cause accumulates
        sw = 1'b1;
        tick();
        sw = 1'b0;
        check("sw_rst",    32'(rst3),   32'h7);
        check("sw_rdy",    32'(rdy3),   32'h0);
        check("sw_cause",  32'(cause3), 32'h7);
        ticks(4);
        check("sw_p4_rst", 32'(rst3),   32'h6);
        ticks(3);
        check("sw_p7_rst", 32'(rst3),   32'h4);
        ticks(3);
        check("sw_p10_rst", 32'(rst3),  32'h0);
        check("sw_p10_rdy", 32'(rdy3),  32'h1);

        // Simultaneous sw+wdt with clear, then clear alone
        sw  = 1'b1;
        wdt = 1'b1;
        clr = 1'b1;
        tick();
        sw  = 1'b0;
        wdt = 1'b0;
        check("both_cause", 32'(cause3), 32'h6);
        check("both_rst",   32'(rst3),   32'h7);
        tick();
        clr = 1'b0;
        check("clr_cause",  32'(cause3), 32'h0);
        ticks(9);
        check("both_p10_rst", 32'(rst3), 32'h0);
        check("both_p10_rdy", 32'(rdy3), 32'h1);

        // Held request: 10 consecutive high samples
        sw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("held_rst", 32'(rst3), 32'h7);
        end
        sw = 1'b0;
        ticks(3);
        check("held_p3_rst",  32'(rst3), 32'h7);
        check("held_p3_rst1", 32'(rst1), 32'h1);
        check("held_p3_rdy1", 32'(rdy1), 32'h0);
        tick();
        check("held_p4_rst",  32'(rst3), 32'h6);
        check("held_p4_rdy",  32'(rdy3), 32'h0);
        check("held_p4_rst1", 32'(rst1), 32'h0);
        check("held_p4_rdy1", 32'(rdy1), 32'h1);
        check("held_cause",   32'(cause3), 32'h2);
        tick();                                     // E0+5 of this sequence

        // Asynchronous abort mid-cycle, request ignored while in reset
        #2;
        rst_n = 1'b0;
        sw    = 1'b1;
        #1;
        check("abort_rst",    32'(rst3),   32'h7);
        check("abort_rdy",    32'(rdy3),   32'h0);
        check("abort_cause",  32'(cause3), 32'h1);
        check("abort_rst1",   32'(rst1),   32'h1);
        check("abort_cause1", 32'(cause1), 32'h1);
        ticks(3);
        check("abort_sw_cause", 32'(cause3), 32'h1);
        sw    = 1'b0;
        rst_n = 1'b1;
        ticks(2);
        check("rel_e0_rst",   32'(rst3),   32'h7);
        check("rel_e0_cause", 32'(cause3), 32'h1);
        ticks(10);
        check("rel_p10_rst",  32'(rst3),   32'h0);
        check("rel_p10_rdy",  32'(rdy3),   32'h1);
        check("rel_p10_rdy1", 32'(rdy1),   32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
